// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: Gray-coded FSM states
// and per-channel mode encodings.
package edge_pkg;

    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_RISE = 2'b01,
        ST_HIGH = 2'b11,
        ST_FALL = 2'b10
    } edge_state_e;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic logic state_level(input edge_state_e st);
        return (st == ST_RISE) || (st == ST_HIGH);
    endfunction

    function automatic logic rise_enabled(input logic [1:0] m);
        return (m == MODE_RISE) || (m == MODE_BOTH);
    endfunction

    function automatic logic fall_enabled(input logic [1:0] m);
        return (m == MODE_FALL) || (m == MODE_BOTH);
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detect channel: synchroniser, stability filter, four-state Moore FSM,
// pulse/level decode and a sticky edge flag.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       pulse,
    output logic       level,
    output logic       flag
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    edge_state_e            state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= x;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The counter only advances while the synchronised input disagrees with the
    // accepted level; any agreeing sample (a glitch ending) drops it back to zero.
    always_comb begin
        state_d = ST_LOW;
        cnt_d   = '0;
        case (state_q)
            ST_LOW: begin
                state_d = ST_LOW;
                if (s) begin
                    if (cnt_q == CNT_LAST) state_d = ST_RISE;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_RISE: state_d = ST_HIGH;
            ST_HIGH: begin
                state_d = ST_HIGH;
                if (!s) begin
                    if (cnt_q == CNT_LAST) state_d = ST_FALL;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_FALL: state_d = ST_LOW;
            default: state_d = ST_LOW;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = state_level(state_q);
    assign pulse = ((state_q == ST_RISE) && rise_enabled(mode)) ||
                   ((state_q == ST_FALL) && fall_enabled(mode));

    // Set has priority so an edge is never lost to a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      flag <= 1'b0;
        else if (pulse) flag <= 1'b1;
        else if (clr)   flag <= 1'b0;
    end

endmodule

// File: rtl/multi_edge_detect.sv
// N-channel debounced edge detector: one edge_chan per input plus a combined
// any-pulse indication.
module multi_edge_detect
    import edge_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   x,
    input  logic [2*N-1:0] mode,
    input  logic [N-1:0]   clr,
    output logic [N-1:0]   pulse,
    output logic [N-1:0]   level,
    output logic [N-1:0]   flag,
    output logic           any_pulse
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .x    (x[i]),
            .mode (mode[2*i+1:2*i]),
            .clr  (clr[i]),
            .pulse(pulse[i]),
            .level(level[i]),
            .flag (flag[i])
        );
    end

    assign any_pulse = |pulse;

endmodule
